// File: rtl/cpu_control_fsm_if.sv
// Control-bus bundle between the CPU control FSM and the datapath.
// The FSM holds the master modport (drives the strobes); the datapath holds the slave modport.
// Optional retire counter output is present when CPU_CTRL_RETIRE_CNT_EN is defined.
interface cpu_control_fsm_if;
    // Datapath -> control
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;

    // Control -> datapath
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_req;
    logic        mem_we;
    logic        reg_write;
    logic        alu_src;
    logic        mem_to_reg;
    logic [2:0]  opsc;
    logic [2:0]  state;
    logic        illegal;
    logic        timeout;
    logic        halted;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [15:0] retire_count;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, alu_src, mem_to_reg,
        output opsc, state, illegal, timeout, halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
        , output retire_count
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, alu_src, mem_to_reg,
        input  opsc, state, illegal, timeout, halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
        , input retire_count
`endif
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB, plus HALT.
// Strobes are decoded combinationally from the state, the latched opcode, zero and mem_ready.
// Memory waits in FETCH/MEM are bounded by TIMEOUT_CYC (0 disables the timeout).
// Define CPU_CTRL_RETIRE_CNT_EN to add a saturating 16-bit retired-instruction counter.
module cpu_control_fsm #(
    parameter logic [3:0] TIMEOUT_CYC = 4'd15
) (
    input  logic              clk,
    input  logic              reset,
    cpu_control_fsm_if.master ctrl_io
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [3:0] OpRtype = 4'h0;
    localparam logic [3:0] OpAddi  = 4'h1;
    localparam logic [3:0] OpLw    = 4'h2;
    localparam logic [3:0] OpSw    = 4'h3;
    localparam logic [3:0] OpBeq   = 4'h4;
    localparam logic [3:0] OpJmp   = 4'h5;
    localparam logic [3:0] OpHalt  = 4'hF;

    localparam logic [1:0] PcInc    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] wait_q, wait_d;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [2:0] opsc;
    logic       illegal;
    logic       timeout;
    logic       halted;
    logic       retire;

    logic       timeout_hit;
    logic [3:0] wait_inc;

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OpRtype) || (op == OpAddi) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpJmp) || (op == OpHalt);
    endfunction

    // A ready memory always wins over an expiring wait counter.
    assign timeout_hit = (TIMEOUT_CYC != 4'd0) && (wait_q == TIMEOUT_CYC) && !ctrl_io.mem_ready;
    assign wait_inc    = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;

    // Next-state, opcode latch, wait counter and strobe decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = '0;  // cleared on any entry into FETCH/MEM
        pc_write   = 1'b0;
        pc_src     = PcInc;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        opsc       = AluAdd;
        illegal    = 1'b0;
        timeout    = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (ctrl_io.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PcInc;
                    state_d  = StDecode;
                end else if (timeout_hit) begin
                    // Retry the fetch; PC was never advanced.
                    timeout = 1'b1;
                    state_d = StFetch;
                end else begin
                    wait_d = wait_inc;
                end
            end

            StDecode: begin
                // The IR is valid now, so decode the live opcode rather than op_q.
                op_d = ctrl_io.opcode;
                if (!is_legal(ctrl_io.opcode)) begin
                    illegal = 1'b1;
                    state_d = StFetch;
                end else if (ctrl_io.opcode == OpHalt) begin
                    state_d = StHalt;
                end else if (ctrl_io.opcode == OpJmp) begin
                    pc_write = 1'b1;
                    pc_src   = PcJump;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else begin
                    state_d = StExec;
                end
            end

            StExec: begin
                case (op_q)
                    OpRtype: begin
                        opsc    = AluFunct;
                        state_d = StWb;
                    end
                    OpAddi: begin
                        opsc    = AluAdd;
                        alu_src = 1'b1;
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        opsc    = AluAdd;
                        alu_src = 1'b1;
                        state_d = StMem;
                    end
                    OpBeq: begin
                        opsc     = AluSub;
                        pc_write = ctrl_io.zero;
                        pc_src   = PcBranch;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end

            StMem: begin
                mem_req = 1'b1;
                if (ctrl_io.mem_ready) begin
                    mem_we = (op_q == OpSw);
                    if (op_q == OpLw) begin
                        state_d = StWb;
                    end else begin
                        retire  = (op_q == OpSw);
                        state_d = StFetch;
                    end
                end else if (timeout_hit) begin
                    // Abort the access: only mem_req stays up in this cycle.
                    timeout = 1'b1;
                    state_d = StFetch;
                end else begin
                    mem_we = (op_q == OpSw);
                    wait_d = wait_inc;
                end
            end

            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OpLw);
                retire     = 1'b1;
                state_d    = StFetch;
            end

            StHalt: begin
                halted  = 1'b1;
                state_d = StHalt;
            end

            default: state_d = StFetch;
        endcase
    end

    // State, opcode latch and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs held at their idle values for as long as reset is asserted.
    assign ctrl_io.pc_write   = pc_write & ~reset;
    assign ctrl_io.pc_src     = reset ? PcInc : pc_src;
    assign ctrl_io.ir_write   = ir_write & ~reset;
    assign ctrl_io.mem_req    = mem_req & ~reset;
    assign ctrl_io.mem_we     = mem_we & ~reset;
    assign ctrl_io.reg_write  = reg_write & ~reset;
    assign ctrl_io.alu_src    = alu_src & ~reset;
    assign ctrl_io.mem_to_reg = mem_to_reg & ~reset;
    assign ctrl_io.opsc       = reset ? AluAdd : opsc;
    assign ctrl_io.state      = reset ? 3'd0 : state_q;
    assign ctrl_io.illegal    = illegal & ~reset;
    assign ctrl_io.timeout    = timeout & ~reset;
    assign ctrl_io.halted     = halted & ~reset;

`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Saturating count of architecturally completed instructions.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire && (retire_cnt_q != 16'hFFFF)) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign ctrl_io.retire_count = retire_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a per-cycle vector table for the instruction flows and
// timeouts, plus hand-written reset/HALT and retire-counter sequences.
module tb_cpu_control_fsm;

    // Bit masks for {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, alu_src,
    //                mem_to_reg, opsc, illegal, timeout, halted}
    localparam logic [14:0] PCW  = 15'h4000;
    localparam logic [14:0] BR   = 15'h1000;
    localparam logic [14:0] JT   = 15'h2000;
    localparam logic [14:0] IRW  = 15'h0800;
    localparam logic [14:0] MREQ = 15'h0400;
    localparam logic [14:0] MWE  = 15'h0200;
    localparam logic [14:0] RW   = 15'h0100;
    localparam logic [14:0] ASRC = 15'h0080;
    localparam logic [14:0] M2R  = 15'h0040;
    localparam logic [14:0] FN   = 15'h0010;
    localparam logic [14:0] SUB  = 15'h0008;
    localparam logic [14:0] ILL  = 15'h0004;
    localparam logic [14:0] TMO  = 15'h0002;
    localparam logic [14:0] HLT  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;
    localparam logic [14:0] FOK  = PCW | IRW | MREQ;

    typedef struct packed {
        logic [3:0]  opcode;
        logic        zero;
        logic        ready;
        logic [2:0]  state;
        logic [14:0] outs;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    cpu_control_fsm_if bus ();

    cpu_control_fsm #(
        .TIMEOUT_CYC(4'd4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ctrl_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] observe();
        return {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_req, bus.mem_we,
                bus.reg_write, bus.alu_src, bus.mem_to_reg, bus.opsc, bus.illegal, bus.timeout,
                bus.halted};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: state/outs got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic z, input logic r);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = r;
    endtask

    task automatic add(input logic [3:0] op, input logic z, input logic r, input logic [2:0] st,
                       input logic [14:0] o);
        vecs.push_back({op, z, r, st, o});
    endtask

    task automatic run_jmp();
        drive(4'h5, 1'b0, 1'b1);
        tick();
        drive(4'h5, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // R-type
        add(4'h0, 0, 1, 3'd0, FOK);
        add(4'h0, 0, 0, 3'd1, NONE);
        add(4'h0, 0, 0, 3'd2, FN);
        add(4'h0, 0, 0, 3'd4, RW);
        // ADDI
        add(4'h1, 0, 1, 3'd0, FOK);
        add(4'h1, 0, 0, 3'd1, NONE);
        add(4'h1, 0, 0, 3'd2, ASRC);
        add(4'h1, 0, 0, 3'd4, RW);
        // LW, memory ready after 3 wait cycles
        add(4'h2, 0, 1, 3'd0, FOK);
        add(4'h2, 0, 0, 3'd1, NONE);
        add(4'h2, 0, 0, 3'd2, ASRC);
        add(4'h2, 0, 0, 3'd3, MREQ);
        add(4'h2, 0, 0, 3'd3, MREQ);
        add(4'h2, 0, 0, 3'd3, MREQ);
        add(4'h2, 0, 1, 3'd3, MREQ);
        add(4'h2, 0, 0, 3'd4, RW | M2R);
        // SW zero-wait
        add(4'h3, 0, 1, 3'd0, FOK);
        add(4'h3, 0, 0, 3'd1, NONE);
        add(4'h3, 0, 0, 3'd2, ASRC);
        add(4'h3, 0, 1, 3'd3, MREQ | MWE);
        // BEQ taken, then not taken
        add(4'h4, 0, 1, 3'd0, FOK);
        add(4'h4, 0, 0, 3'd1, NONE);
        add(4'h4, 1, 0, 3'd2, PCW | BR | SUB);
        add(4'h4, 0, 1, 3'd0, FOK);
        add(4'h4, 0, 0, 3'd1, NONE);
        add(4'h4, 0, 0, 3'd2, BR | SUB);
        // JMP
        add(4'h5, 0, 1, 3'd0, FOK);
        add(4'h5, 0, 0, 3'd1, PCW | JT);
        // Illegal opcode 1010
        add(4'hA, 0, 1, 3'd0, FOK);
        add(4'hA, 0, 0, 3'd1, ILL);
        // Fetch with 2 waits, then mem_ready outside FETCH/MEM is ignored
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 1, 3'd0, FOK);
        add(4'h0, 0, 1, 3'd1, NONE);
        add(4'h0, 0, 1, 3'd2, FN);
        add(4'h0, 0, 1, 3'd4, RW);
        // SW times out on the 5th MEM cycle (TIMEOUT_CYC=4)
        add(4'h3, 0, 1, 3'd0, FOK);
        add(4'h3, 0, 0, 3'd1, NONE);
        add(4'h3, 0, 0, 3'd2, ASRC);
        add(4'h3, 0, 0, 3'd3, MREQ | MWE);
        add(4'h3, 0, 0, 3'd3, MREQ | MWE);
        add(4'h3, 0, 0, 3'd3, MREQ | MWE);
        add(4'h3, 0, 0, 3'd3, MREQ | MWE);
        add(4'h3, 0, 0, 3'd3, MREQ | TMO);
        // Back in FETCH: mem_ready in the would-be timeout cycle wins, then JMP
        add(4'h5, 0, 0, 3'd0, MREQ);
        add(4'h5, 0, 0, 3'd0, MREQ);
        add(4'h5, 0, 0, 3'd0, MREQ);
        add(4'h5, 0, 0, 3'd0, MREQ);
        add(4'h5, 0, 1, 3'd0, FOK);
        add(4'h5, 0, 0, 3'd1, PCW | JT);
        // FETCH timeout, counter restarts, then an R-type completes
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 0, 3'd0, MREQ | TMO);
        add(4'h0, 0, 0, 3'd0, MREQ);
        add(4'h0, 0, 1, 3'd0, FOK);
        add(4'h0, 0, 0, 3'd1, NONE);
        add(4'h0, 0, 0, 3'd2, FN);
        add(4'h0, 0, 0, 3'd4, RW);

        // Reset: outputs idle even with mem_ready high
        reset = 1'b1;
        drive(4'h0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("reset_idle", observe(), {3'd0, NONE});
`ifdef CPU_CTRL_RETIRE_CNT_EN
        check16("reset_retire", bus.retire_count, 16'd0);
`endif
        tick();
        reset = 1'b0;
        drive(4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_fetch", observe(), {3'd0, MREQ});
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].opcode, vecs[i].zero, vecs[i].ready);
            @(negedge clk);
            check($sformatf("vec%0d", i), observe(), {vecs[i].state, vecs[i].outs});
            tick();
        end

`ifdef CPU_CTRL_RETIRE_CNT_EN
        // R, ADDI, LW, SW, BEQ x2, JMP, R, JMP, R; illegal and timeouts excluded
        check16("retire_after_table", bus.retire_count, 16'd10);
`endif

        // HALT holds and ignores mem_ready; reset from HALT acts asynchronously
        drive(4'hF, 1'b0, 1'b1);
        tick();
        drive(4'hF, 1'b0, 1'b0);
        tick();
        drive(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("halt%0d", i), observe(), {3'd5, HLT});
            tick();
        end
`ifdef CPU_CTRL_RETIRE_CNT_EN
        check16("retire_halt", bus.retire_count, 16'd10);
`endif
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_from_halt", observe(), {3'd0, NONE});
        tick();
        reset = 1'b0;
        drive(4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("fetch_after_halt_reset", observe(), {3'd0, MREQ});
        tick();

`ifdef CPU_CTRL_RETIRE_CNT_EN
        check16("retire_cleared", bus.retire_count, 16'd0);
        for (int i = 0; i < 3; i++) run_jmp();
        check16("retire_three_jmp", bus.retire_count, 16'd3);
        @(negedge clk);
        dut.retire_cnt_q = 16'hFFFD;
        tick();
        for (int i = 0; i < 3; i++) run_jmp();
        check16("retire_saturate", bus.retire_count, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
